// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word sender.
package serial_pkg;

    typedef enum logic {IDLE, SHIFT} sender_state_t;

    localparam int SER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/serial_word_sender_if.sv
// Upstream valid/ready word handshake for the serial word sender.
interface serial_word_sender_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/word_fifo.sv
// Small word FIFO with a registered head word, so a pop can load it on the same edge.
module word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    rd_ptr_next;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + PW'(1);

    // The head register always holds the word at rd_ptr, refilled on every pop
    // or on a push into an empty FIFO.
    always_comb begin
        head_next = head_reg;
        if (do_pop) begin
            if (level_reg > LW'(1))
                head_next = mem[rd_ptr_next];
            else if (do_push)
                head_next = wdata;
        end else if (empty && do_push) begin
            head_next = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            head_reg <= head_next;
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rdata = head_reg;
    assign level = level_reg;

endmodule

// File: rtl/serial_word_sender.sv
// Buffers parallel words and shifts them out MSB-first, one bit per cycle.
// Optional SENDER_GAP_EN inserts one idle cycle after every word.
module serial_word_sender
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_sender_if.slave    up,
    output logic                   ser_out,
    output logic                   ser_en,
    output logic                   word_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sender_state_t    state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    bitcnt_reg, bitcnt_next;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             last_bit;

    assign fifo_push   = up.in_valid && !fifo_full;
    assign up.in_ready = !fifo_full;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (up.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign last_bit = (bitcnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        bitcnt_next = bitcnt_reg;
        fifo_pop    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shreg_next  = fifo_rdata;
                    bitcnt_next = '0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_next  = {shreg_reg[WIDTH-2:0], 1'b0};
                bitcnt_next = bitcnt_reg + CW'(1);
                if (last_bit) begin
`ifdef SENDER_GAP_EN
                    state_next = IDLE;
`else
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        shreg_next  = fifo_rdata;
                        bitcnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            shreg_reg  <= shreg_next;
            bitcnt_reg <= bitcnt_next;
        end
    end

    assign ser_en    = (state_reg == SHIFT);
    assign ser_out   = ser_en && shreg_reg[WIDTH-1];
    assign word_done = ser_en && last_bit;
    assign busy      = ser_en || !fifo_empty;

endmodule

// File: doc/serial_word_sender.md
# serial_word_sender

Upstream feeder for the 4-bit shift/parallel register. Accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and serialises each word MSB-first onto `ser_out`, one bit per cycle. `ser_en` drives the register's `SEL`, so after WIDTH enabled cycles the register holds the word exactly. A one-cycle `word_done` pulse marks the last bit.

## Interface
- `WIDTH`, default 4: word width in bits; must be ≥ 2.
- `DEPTH`, default 2: FIFO entries; power of two, ≥ 2.
- `clk`  input  1: rising-edge clock; the only clock.
- `reset`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: FIFO can accept a word; equals not-full.
- `in_data`  input  WIDTH: parallel word to send.
- `ser_out`  output  1: serial bit, driven to the register's `Din_serie`.
- `ser_en`  output  1: bit on `ser_out` is valid; driven to the register's `SEL`.
- `word_done`  output  1: one-cycle pulse, high together with the last bit of a word.
- `busy`  output  1: high when the FSM is in SHIFT or the FIFO is non-empty.
- `level`  output  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- A push occurs on any rising edge with `in_valid && in_ready`. The word is written at the FIFO tail.
- FSM states are IDLE and SHIFT. On reset the FSM enters IDLE.
- **IDLE:**
  - If the FIFO is non-empty, pop the head into shift register `shreg`, clear `bitcnt`, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:**
  - `ser_en` = 1 and `ser_out` = `shreg[WIDTH-1]`.
  - Each edge shifts `shreg` left and increments `bitcnt`.
- **Last bit** (`bitcnt == WIDTH-1`):
  - `word_done` = 1 in that cycle.
  - On the edge, if the FIFO is non-empty: pop the next word, clear `bitcnt`, and stay in SHIFT. Words go out back-to-back with no gap.
  - If the FIFO is empty: go to IDLE.
- `ser_out` = 0 whenever `ser_en` = 0.
- **Full FIFO:** `in_ready` = 0. A push is not allowed in the same cycle as a pop; there is no bypass.
- **Empty FIFO:** no pop occurs and the FSM stays in, or returns to, IDLE.
- **Simultaneous push and pop when not full:** both take effect. `level` is unchanged.
- FIFO pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `level` is tracked separately.
- **Reset mid-word:** the word in flight and all queued words are discarded. No partial word is resumed.

## Timing
- Reset values take effect from the cycle after a reset edge:
  - `ser_en`, `ser_out`, `word_done`, `busy`, `level` = 0.
  - `in_ready` = 1.
  - FSM in IDLE.
- Outputs are decoded from registers only. There is no combinational path from `in_valid`/`in_data` to the serial outputs.
- **Latency:** a push on edge k gives the first bit (MSB) with `ser_en` = 1 in cycle k+2 (after edge k+1 loads it). The last bit and `word_done` occur in cycle k+1+WIDTH.
- **Throughput:** one word per WIDTH cycles in steady state.
- `level` updates on the edge of a push or pop.
- `in_ready` reflects the registered `level`.

## Configuration
- **`SENDER_GAP_EN` defined:**
  - After each last bit the FSM always passes through IDLE for exactly one cycle with `ser_en` = 0, even if the FIFO is non-empty.
  - This gives the downstream `Dout` one stable parallel-view cycle between words.
  - Steady-state throughput is one word per WIDTH+1 cycles.
- **Undefined:** back-to-back behaviour as described in Operation.

## Structure
- Package `serial_pkg`:
  - `typedef enum logic {IDLE, SHIFT} sender_state_t`.
  - Localparam `SER_WIDTH_DEFAULT = 4`.
- Sub-module `word_fifo`, parameterised by WIDTH and DEPTH:
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Synchronous read of the head; reset on the same `reset`.
- The top level holds the FSM, `shreg` and `bitcnt`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid` = 1. Expect `in_ready` = 1, `ser_en` = 0, `level` = 0, and no push recorded.
- **Single word:** push 4'b1011 at edge k. Expect `ser_out` sequence 1,0,1,1 with `ser_en` = 1 in cycles k+2..k+5, and `word_done` only in k+5. The downstream register model shows `Dout` = 4'b1011.
- **Back-to-back:** push 4'hA, 4'h5, 4'hC with `in_valid` held high. Expect `in_ready` = 0 once `level` = 2. Expect 12 consecutive `ser_en` cycles emitting 1010 0101 1100, and 3 `word_done` pulses spaced 4 cycles apart.
- **Full boundary:** with the FIFO full and the FSM popping, hold `in_valid` = 1. Expect no push in the pop cycle, and a push accepted on the following edge.
- **Reset mid-word:** assert `reset` after the 2nd bit of 4'hF with 1 word queued. Expect `ser_en` = 0 and `level` = 0 from the next cycle, and no further bits.
- **Gap mode:** with `SENDER_GAP_EN` defined, push 4'h3 and 4'h9 back-to-back. Expect exactly one `ser_en` = 0 cycle between the two words.
